// File: rtl/quaternion_integrator.sv
// Quaternion integrator: q_next = q + q_dot*dt per component, one shared multiplier.
// Build option QUAT_INTEGRATOR_SATURATE_EN enables clamping and sat_flag; otherwise sums wrap.

module quat_comp_step #(
  parameter int W  = 16,
  parameter int DT = 16
) (
  input  logic signed [W-1:0]  q,
  input  logic signed [W-1:0]  q_dot,
  input  logic        [DT-1:0] dt,
`ifdef QUAT_INTEGRATOR_SATURATE_EN
  output logic                 clip,
`endif
  output logic        [W-1:0]  sum
);
  localparam int PW = W + DT + 1;
  localparam logic signed [PW-1:0] HALF = PW'(1) << (DT - 1);

  logic signed [PW-1:0] p;
  logic signed [PW-1:0] sh;
  logic        [W:0]    sum_w;
  logic                 unused_bits;

  // |delta| never exceeds |q_dot|, so the rounded product fits in W+1 bits.
  always_comb begin
    p     = PW'(q_dot) * PW'($signed({1'b0, dt}));
    sh    = (p + HALF) >>> DT;
    sum_w = {q[W-1], q} + sh[W:0];
  end

`ifdef QUAT_INTEGRATOR_SATURATE_EN
  always_comb begin
    clip = sum_w[W] ^ sum_w[W-1];
    sum  = clip ? {sum_w[W], {(W-1){~sum_w[W]}}} : sum_w[W-1:0];
  end
  assign unused_bits = ^sh[PW-1:W+1];
`else
  assign sum         = sum_w[W-1:0];
  assign unused_bits = ^{sh[PW-1:W+1], sum_w[W]};
`endif
endmodule

module quaternion_integrator #(
  parameter int INT_WIDTH      = 8,
  parameter int FRACT_WIDTH    = 8,
  parameter int DT_FRACT_WIDTH = 16
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      start,
  output logic                                      done,
  input  logic [DT_FRACT_WIDTH-1:0]                 dt,
  input  logic [4*(INT_WIDTH+FRACT_WIDTH)-1:0]      q_in,
  input  logic [4*(INT_WIDTH+FRACT_WIDTH)-1:0]      q_dot_in,
  output logic [4*(INT_WIDTH+FRACT_WIDTH)-1:0]      data_out,
  output logic                                      sat_flag
);
  localparam int W  = INT_WIDTH + FRACT_WIDTH;
  localparam int DT = DT_FRACT_WIDTH;

  typedef enum logic [1:0] {IDLE, LOAD, MULT, DONE} state_t;

  state_t              state;
  logic [3:0][W-1:0]   q_r;
  logic [3:0][W-1:0]   qd_r;
  logic [DT-1:0]       dt_r;
  logic [1:0]          idx;
  logic [2:0][W-1:0]   res;
  logic [W-1:0]        sum_c;
`ifdef QUAT_INTEGRATOR_SATURATE_EN
  logic                clip_c;
  logic                acc;
`endif

  quat_comp_step #(.W(W), .DT(DT)) u_step (
    .q     (q_r[idx]),
    .q_dot (qd_r[idx]),
    .dt    (dt_r),
`ifdef QUAT_INTEGRATOR_SATURATE_EN
    .clip  (clip_c),
`endif
    .sum   (sum_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      done     <= 1'b0;
      data_out <= '0;
      q_r      <= '0;
      qd_r     <= '0;
      dt_r     <= '0;
      idx      <= '0;
      res      <= '0;
`ifdef QUAT_INTEGRATOR_SATURATE_EN
      acc      <= 1'b0;
      sat_flag <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) state <= LOAD;
        end
        LOAD: begin
          q_r   <= q_in;
          qd_r  <= q_dot_in;
          dt_r  <= dt;
          idx   <= '0;
`ifdef QUAT_INTEGRATOR_SATURATE_EN
          acc   <= 1'b0;
`endif
          state <= MULT;
        end
        MULT: begin
`ifdef QUAT_INTEGRATOR_SATURATE_EN
          acc <= acc | clip_c;
`endif
          // z goes straight to data_out so the result lands on the index-3 edge.
          if (idx == 2'd3) begin
            data_out <= {sum_c, res[2], res[1], res[0]};
`ifdef QUAT_INTEGRATOR_SATURATE_EN
            sat_flag <= acc | clip_c;
`endif
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            case (idx)
              2'd0:    res[0] <= sum_c;
              2'd1:    res[1] <= sum_c;
              default: res[2] <= sum_c;
            endcase
            idx <= idx + 2'd1;
          end
        end
        DONE: begin
          if (!start) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef QUAT_INTEGRATOR_SATURATE_EN
  assign sat_flag = 1'b0;
`endif
endmodule

// File: tb/tb_quaternion_integrator.sv
// Self-checking bench for quaternion_integrator against an integer reference model.
module tb_quaternion_integrator;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        done;
  logic [15:0] dt = '0;
  logic [63:0] q_in = '0;
  logic [63:0] q_dot_in = '0;
  logic [63:0] data_out;
  logic        sat_flag;

  int checks = 0;
  int failures = 0;

  quaternion_integrator dut (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done), .dt(dt),
    .q_in(q_in), .q_dot_in(q_dot_in), .data_out(data_out), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  // q + round(q_dot*dt/2^16), rounding half up, then clamp (or wrap).
  function automatic void model(input logic [63:0] q, input logic [63:0] qd,
                                input logic [15:0] d, output logic [63:0] r, output bit s);
    longint qi, qdi, num, delta, sum;
    logic [63:0] sv;
    s = 1'b0;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      qi  = longint'($signed(q[i*16 +: 16]));
      qdi = longint'($signed(qd[i*16 +: 16]));
      num = qdi * longint'(d) + 32768;
      delta = (num >= 0) ? num / 65536 : -((-num + 65535) / 65536);
      sum = qi + delta;
`ifdef QUAT_INTEGRATOR_SATURATE_EN
      if (sum > 32767)  begin sum = 32767;  s = 1'b1; end
      if (sum < -32768) begin sum = -32768; s = 1'b1; end
`endif
      sv = 64'(sum);
      r[i*16 +: 16] = sv[15:0];
    end
  endfunction

  // Start a run and wait for done; inputs are scrambled once they are captured.
  task automatic do_run(input logic [63:0] q, input logic [63:0] qd, input logic [15:0] d,
                        input bit toggle, output int cyc);
    @(negedge clk);
    q_in = q; q_dot_in = qd; dt = d; start = 1'b1;
    cyc = 0;
    while (cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (done) break;
      @(negedge clk);
      if (cyc >= 2) begin
        q_in = {$urandom, $urandom}; q_dot_in = {$urandom, $urandom}; dt = 16'($urandom);
      end
      if (toggle && cyc >= 1) start = (cyc == 5) ? 1'b1 : 1'($urandom);
    end
  endtask

  task automatic end_run(input string name);
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      failures++; $display("FAIL %s done_drop: got %b want 0", name, done);
    end
  endtask

  task automatic check_run(input string name, input logic [63:0] q, input logic [63:0] qd,
                           input logic [15:0] d, input bit toggle);
    int cyc;
    logic [63:0] exp_r;
    bit exp_s;
    model(q, qd, d, exp_r, exp_s);
    do_run(q, qd, d, toggle, cyc);
    checks++;
    if (cyc != 6 || done !== 1'b1) begin
      failures++; $display("FAIL %s latency: got %0d cycles done=%b want 6 cycles done=1", name, cyc, done);
    end
    checks++;
    if (data_out !== exp_r) begin
      failures++; $display("FAIL %s data_out: got %h want %h", name, data_out, exp_r);
    end
    checks++;
    if (sat_flag !== exp_s) begin
      failures++; $display("FAIL %s sat_flag: got %b want %b", name, sat_flag, exp_s);
    end
    end_run(name);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || data_out !== 64'h0 || sat_flag !== 1'b0) begin
      failures++; $display("FAIL reset: got done=%b data=%h sat=%b want 0/0/0", done, data_out, sat_flag);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_directed();
    int cyc;
    check_run("basic", 64'h0000_0000_0000_0100, 64'h0000_0000_0080_0000, 16'h028F, 1'b0);
    checks++;
    if (data_out !== 64'h0000_0000_0001_0100) begin
      failures++; $display("FAIL basic_const: got %h want 0000000000010100", data_out);
    end
    check_run("neg_round", 64'h0000_0000_0000_0100, 64'h0000_0000_0000_FF00, 16'h8000, 1'b0);
    checks++;
    if (data_out !== 64'h0000_0000_0000_0080) begin
      failures++; $display("FAIL neg_round_const: got %h want 0000000000000080", data_out);
    end
    check_run("pos_sat", 64'h0000_0000_7F00_0000, 64'h0000_0000_7FFF_0000, 16'hFFFF, 1'b0);
    check_run("neg_sat", 64'h0000_8000_0000_0000, 64'h0000_8000_0000_0000, 16'hFFFF, 1'b0);
`ifdef QUAT_INTEGRATOR_SATURATE_EN
    checks++;
    if (data_out[47:32] !== 16'h8000) begin
      failures++; $display("FAIL neg_sat_const: got %h want 8000", data_out[47:32]);
    end
`endif
    do_run(64'h1234_8000_7F00_0100, 64'h7FFF_8000_7FFF_8000, 16'h0000, 1'b0, cyc);
    checks++;
    if (data_out !== 64'h1234_8000_7F00_0100 || sat_flag !== 1'b0) begin
      failures++; $display("FAIL dt_zero: got %h sat=%b want 123480007f000100 sat=0", data_out, sat_flag);
    end
    end_run("dt_zero");
  endtask

  task automatic test_random();
    logic [63:0] q, qd;
    logic [15:0] d;
    for (int n = 0; n < 30; n++) begin
      q  = {$urandom, $urandom};
      qd = {$urandom, $urandom};
      case (n % 4)
        0: d = 16'hFFFF;
        1: d = 16'h0000;
        default: d = 16'($urandom);
      endcase
      check_run("random", q, qd, d, n[0]);
    end
  endtask

  task automatic test_handshake();
    int cyc;
    logic [63:0] exp_r, held;
    bit exp_s;
    model(64'h0200_FE00_0100_0040, 64'h1000_F000_0800_8000, 16'h4000, exp_r, exp_s);
    do_run(64'h0200_FE00_0100_0040, 64'h1000_F000_0800_8000, 16'h4000, 1'b0, cyc);
    checks++;
    if (cyc != 6 || data_out !== exp_r) begin
      failures++; $display("FAIL hs_first: got cyc=%0d data=%h want cyc=6 data=%h", cyc, data_out, exp_r);
    end
    held = data_out;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); q_in = {$urandom, $urandom}; q_dot_in = {$urandom, $urandom}; dt = 16'($urandom);
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b1 || data_out !== held) begin
        failures++; $display("FAIL hs_hold: got done=%b data=%h want 1 %h", done, data_out, held);
      end
    end
    end_run("hs_drop");
    @(posedge clk); #1;
    checks++;
    if (data_out !== held) begin
      failures++; $display("FAIL hs_idle_keep: got %h want %h", data_out, held);
    end
    check_run("hs_rerun", 64'h0001_0002_0003_0004, 64'h0400_0300_0200_0100, 16'h2000, 1'b0);
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    q_in = 64'h0100_0100_0100_0100; q_dot_in = 64'h0100_0100_0100_0100; dt = 16'h8000; start = 1'b1;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (done !== 1'b0 || data_out !== 64'h0 || sat_flag !== 1'b0) begin
      failures++; $display("FAIL midop_reset: got done=%b data=%h sat=%b want 0/0/0", done, data_out, sat_flag);
    end
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || data_out !== 64'h0) begin
      failures++; $display("FAIL midop_after: got done=%b data=%h want 0/0", done, data_out);
    end
    check_run("midop_rerun", 64'h0100_0100_0100_0100, 64'h0100_0100_0100_0100, 16'h8000, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_handshake();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
